// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : key_debouncer
// Purpose  : Conditions active-low push-buttons for the game FSM. Each key
//            gets a 2-flop synchronizer, a tick-based debounce filter and
//            registered one-cycle press / release / long-press strobes.
//            The shared 1 ms strobe keeps the per-key counters narrow.
// Ports    : clk          system clock
//            reset        synchronous, active-high reset
//            tick_1ms     one-cycle strobe, once per millisecond
//            key_n        raw active-low buttons, asynchronous to clk
//            key_level    debounced level, 1 = pressed
//            key_press    one-cycle pulse on accepted press
//            key_release  one-cycle pulse on accepted release
//            key_long     one-cycle pulse once per press after HOLD_TICKS held
// Revision : 1.0 - initial release
// ============================================================================
module key_debouncer #(
    parameter int N_KEYS         = 4,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int HOLD_TICKS     = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1ms,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    localparam int c_CNT_W = $clog2(HOLD_TICKS + 1);
    localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD    = c_CNT_W'(HOLD_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // Two-flop synchronizer; inversion up front makes 1 mean "pressed".
    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        state_t               state_q, state_d;
        logic [c_CNT_W-1:0]   cnt_q, cnt_d;
        logic                 long_done_q, long_done_d;
        logic                 level_q, level_d;
        logic                 press_q, press_d;
        logic                 release_q, release_d;
        logic                 long_q, long_d;
        logic                 w_s;

        assign w_s = sync2_q[k];

        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            long_done_d = long_done_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            long_d      = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (w_s) begin
                        state_d = ST_PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    // A revert wins over a coincident tick.
                    if (!w_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (tick_1ms) begin
                        if (cnt_q == c_DB_LAST) begin
                            state_d = ST_PRESSED;
                            cnt_d   = '0;
                            press_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_PRESSED: begin
                    // Counter saturates at HOLD, so the compare is seen one
                    // cycle after the count lands there; long_done limits it
                    // to one pulse per press.
                    if ((cnt_q == c_HOLD) && !long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                    if (!w_s) begin
                        state_d = ST_RELEASE_WAIT;
                        cnt_d   = '0;
                    end else if (tick_1ms && (cnt_q != c_HOLD)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    // Bounce back to pressed restarts the hold count, but
                    // long_done is kept so key_long cannot fire twice.
                    if (w_s) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else if (tick_1ms) begin
                        if (cnt_q == c_DB_LAST) begin
                            state_d     = ST_IDLE;
                            cnt_d       = '0;
                            long_done_d = 1'b0;
                            release_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q     <= ST_IDLE;
                cnt_q       <= '0;
                long_done_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                long_done_q <= long_done_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                long_q      <= long_d;
            end
        end

        assign key_level[k]   = level_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_long[k]    = long_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debouncer
// Purpose  : Self-checking bench for key_debouncer. A level/mismatch-run model
//            predicts every output each cycle; directed scenarios pin timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debouncer;

    localparam int N    = 4;
    localparam int DB   = 4;
    localparam int HOLD = 10;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         tick_1ms = 1'b0;
    logic [N-1:0] key_n    = '1;
    logic [N-1:0] key_level, key_press, key_release, key_long;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int tick_div = 0;

    key_debouncer #(.N_KEYS(N), .DEBOUNCE_TICKS(DB), .HOLD_TICKS(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1ms   (tick_1ms),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // 1 ms strobe: one clk high every 5 clk
    always @(negedge clk) begin
        tick_div = (tick_div == 4) ? 0 : tick_div + 1;
        tick_1ms = (tick_div == 0);
    end

    // ---------------- behavioural model ----------------
    // Accepted level L; a "mismatch run" counts ticks for which the
    // synchronized input has disagreed with L without interruption (the
    // first disagreeing cycle only arms the run). DB such ticks flip L.
    bit m_s1[N], m_s2[N], m_L[N], m_mis[N], m_ld[N];
    int m_run[N], m_hold[N];
    logic [N-1:0] exp_level = '0, exp_press = '0, exp_rel = '0, exp_long = '0;

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_L[k] = 0; m_mis[k] = 0; m_ld[k] = 0;
                m_run[k] = 0; m_hold[k] = 0;
            end
            exp_level = '0; exp_press = '0; exp_rel = '0; exp_long = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                bit s, np, nr, nl;
                s = m_s2[k]; np = 0; nr = 0; nl = 0;
                if (m_L[k] && !m_mis[k] && m_hold[k] == HOLD && !m_ld[k]) begin
                    nl = 1; m_ld[k] = 1;
                end
                if (!m_mis[k]) begin
                    if (s != m_L[k]) begin
                        m_mis[k] = 1; m_run[k] = 0;
                    end else if (m_L[k] && tick_1ms && m_hold[k] < HOLD) begin
                        m_hold[k]++;
                    end
                end else begin
                    if (s == m_L[k]) begin
                        m_mis[k] = 0; m_run[k] = 0;
                        if (m_L[k]) m_hold[k] = 0;
                    end else if (tick_1ms) begin
                        m_run[k]++;
                        if (m_run[k] == DB) begin
                            m_L[k] = s; m_mis[k] = 0; m_run[k] = 0; m_hold[k] = 0;
                            if (s) np = 1;
                            else begin nr = 1; m_ld[k] = 0; end
                        end
                    end
                end
                exp_level[k] = m_L[k];
                exp_press[k] = np;
                exp_rel[k]   = nr;
                exp_long[k]  = nl;
                m_s2[k] = m_s1[k];
                m_s1[k] = ~key_n[k];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            total += 4;
            if (key_level !== exp_level) begin
                bad++; $display("FAIL level cyc=%0d: got %b want %b", cyc, key_level, exp_level);
            end
            if (key_press !== exp_press) begin
                bad++; $display("FAIL press cyc=%0d: got %b want %b", cyc, key_press, exp_press);
            end
            if (key_release !== exp_rel) begin
                bad++; $display("FAIL release cyc=%0d: got %b want %b", cyc, key_release, exp_rel);
            end
            if (key_long !== exp_long) begin
                bad++; $display("FAIL long cyc=%0d: got %b want %b", cyc, key_long, exp_long);
            end
        end
    end

    // ---------------- pulse monitor ----------------
    int n_press[N], n_rel[N], n_long[N];
    int press_cyc[N], long_cyc[N];
    initial for (int k = 0; k < N; k++) begin
        n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0; press_cyc[k] = 0; long_cyc[k] = 0;
    end
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (key_press[k] === 1'b1)   begin n_press[k]++; press_cyc[k] = cyc; end
            if (key_release[k] === 1'b1) n_rel[k]++;
            if (key_long[k] === 1'b1)    begin n_long[k]++; long_cyc[k] = cyc; end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_press(input int k, input int base, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (n_press[k] > base) begin ok = 1; break; end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int t0, b0, b1, b2, b3, r0, l0;
        int dur[N];
        int rst_cnt;

        idle(2);
        chk_en = 1'b1;
        check("reset_level", int'(key_level), 0);
        check("reset_strobes", int'(key_press | key_release | key_long), 0);
        reset = 1'b0;
        idle(10);

        // 1: single press on key 0
        b0 = n_press[0];
        @(negedge clk); key_n[0] = 1'b0; t0 = cyc;
        wait_press(0, b0, 40, ok);
        check("s1_press_seen", int'(ok), 1);
        check("s1_latency_ok", int'((press_cyc[0] - t0 - 1) >= 17 && (press_cyc[0] - t0 - 1) <= 22), 1);
        @(negedge clk); #1;
        check("s1_single_pulse", int'(key_press[0]), 0);
        check("s1_level", int'(key_level), 1);
        key_n[0] = 1'b1;
        idle(40);

        // 2: bounce on key 1
        b1 = n_press[1];
        key_n[1] = 1'b0;
        idle(15);
        check("s2_no_early_press", n_press[1] - b1, 0);
        key_n[1] = 1'b1;
        idle(1);
        key_n[1] = 1'b0; t0 = cyc;
        wait_press(1, b1, 40, ok);
        check("s2_press_seen", int'(ok), 1);
        check("s2_latency_ok", int'((press_cyc[1] - t0 - 1) >= 17), 1);
        idle(10);
        check("s2_one_press", n_press[1] - b1, 1);
        key_n[1] = 1'b1;
        idle(40);

        // 3: long hold on key 3
        b3 = n_press[3]; l0 = n_long[3]; r0 = n_rel[3];
        key_n[3] = 1'b0;
        idle(125);
        check("s3_one_press", n_press[3] - b3, 1);
        check("s3_one_long", n_long[3] - l0, 1);
        check("s3_long_delay_ok", int'((long_cyc[3] - press_cyc[3]) >= 47 && (long_cyc[3] - press_cyc[3]) <= 51), 1);
        key_n[3] = 1'b1;
        idle(40);
        check("s3_one_release", n_rel[3] - r0, 1);
        check("s3_level_low", int'(key_level[3]), 0);

        // 4: release glitch on key 2
        key_n[2] = 1'b0;
        idle(40);
        b2 = n_press[2]; r0 = n_rel[2];
        key_n[2] = 1'b1;
        idle(10);
        key_n[2] = 1'b0;
        idle(40);
        check("s4_level_held", int'(key_level[2]), 1);
        check("s4_no_press", n_press[2] - b2, 0);
        check("s4_no_release", n_rel[2] - r0, 0);
        key_n[2] = 1'b1;
        idle(40);

        // 5: reset mid press-wait, key held through
        b0 = n_press[0];
        key_n[0] = 1'b0;
        idle(8);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s5_outs_in_reset", int'(key_level | key_press | key_release | key_long), 0);
        end
        reset = 1'b0; t0 = cyc;
        wait_press(0, b0, 40, ok);
        check("s5_press_seen", int'(ok), 1);
        check("s5_latency_ok", int'((press_cyc[0] - t0 - 1) >= 17 && (press_cyc[0] - t0 - 1) <= 22), 1);
        key_n[0] = 1'b1;
        idle(40);

        // 6: keys 0 and 3 pressed together
        b0 = n_press[0]; b3 = n_press[3];
        key_n[0] = 1'b0; key_n[3] = 1'b0;
        wait_press(0, b0, 40, ok);
        check("s6_press_seen", int'(ok), 1);
        check("s6_both_pressed", n_press[3] - b3, 1);
        check("s6_same_cycle", press_cyc[3], press_cyc[0]);
        key_n[0] = 1'b1; key_n[3] = 1'b1;
        idle(40);

        // random phase
        for (int k = 0; k < N; k++) dur[k] = $urandom_range(1, 40);
        rst_cnt = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (dur[k] == 0) begin
                    int r;
                    key_n[k] = ~key_n[k];
                    r = $urandom_range(0, 9);
                    if (r < 3)      dur[k] = $urandom_range(1, 8);
                    else if (r < 8) dur[k] = $urandom_range(10, 60);
                    else            dur[k] = $urandom_range(60, 160);
                end else begin
                    dur[k]--;
                end
            end
            if (rst_cnt > 0) rst_cnt--;
            else if ($urandom_range(0, 999) == 0) rst_cnt = $urandom_range(1, 3);
            reset = (rst_cnt > 0);
        end
        reset = 1'b0;
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
